// File: rtl/branch_pred_pkg.sv
// Shared types and helpers for the pattern-history-table branch predictor.
// ctr_t, CTR_MAX/CTR_MIN and sat_step describe the default 2-bit counter;
// counters of other widths use the generic path inside bp_sat_ctr.
package branch_pred_pkg;

    localparam int PHT_CTR_W = 2;

    typedef logic [PHT_CTR_W-1:0] ctr_t;

    localparam ctr_t CTR_MAX = '1;
    localparam ctr_t CTR_MIN = '0;

    // Saturating up/down step of a single counter.
    function automatic ctr_t sat_step(ctr_t c, logic taken);
        ctr_t n;
        n = c;
        if (taken) begin
            if (c != CTR_MAX) n = c + ctr_t'(1);
        end else begin
            if (c != CTR_MIN) n = c - ctr_t'(1);
        end
        return n;
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// One saturating prediction counter with enable and async reset to INIT_CTR.
module bp_sat_ctr
    import branch_pred_pkg::*;
#(
    parameter int CTR_W    = 2,
    parameter int INIT_CTR = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             taken_i,
    output logic [CTR_W-1:0] ctr_o
);

    logic [CTR_W-1:0] ctr_q;
    logic [CTR_W-1:0] ctr_d;

    generate
        if (CTR_W == PHT_CTR_W) begin : g_pkg_step
            // Default width: reuse the shared step function.
            always_comb begin
                ctr_d = ctr_q;
                if (en_i) ctr_d = sat_step(ctr_t'(ctr_q), taken_i);
            end
        end else begin : g_generic_step
            // Other widths: same saturating rule written out directly.
            always_comb begin
                ctr_d = ctr_q;
                if (en_i) begin
                    if (taken_i) begin
                        if (ctr_q != '1) ctr_d = ctr_q + 1'b1;
                    end else begin
                        if (ctr_q != '0) ctr_d = ctr_q - 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ctr_q <= CTR_W'(INIT_CTR);
        else       ctr_q <= ctr_d;
    end

    assign ctr_o = ctr_q;

endmodule

// File: rtl/branch_pht.sv
// Pattern-history-table branch predictor: ENTRIES saturating counters indexed
// by PC, combinational lookup in ID, write-back of the resolved outcome from EX,
// and a saturating mispredict counter.
// Optional gshare hashing (global history XOR'd into the lookup index) is
// enabled by defining BRANCH_PHT_GSHARE_EN; the port list does not change.
module branch_pht
    import branch_pred_pkg::*;
#(
    parameter int ENTRIES  = 64,
    parameter int CTR_W    = 2,
    parameter int INIT_CTR = 2,
    parameter int PC_LSB   = 2,
    parameter int CNT_W    = 16,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       lookup_pc_i,
    output logic              predict_o,
    output logic [IDX_W-1:0]  lookup_idx_o,
    input  logic              update_i,
    input  logic [IDX_W-1:0]  update_idx_i,
    input  logic              result_i,
    input  logic              update_pred_i,
    input  logic              stall_i,
    output logic [CNT_W-1:0]  mispredict_cnt_o
);

    logic             commit;
    logic [IDX_W-1:0] base_idx;
    logic [IDX_W-1:0] look_idx;
    logic [CTR_W-1:0] ctr_val [ENTRIES];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [31:0]      unused_pc;

    assign unused_pc = lookup_pc_i;
    assign commit    = update_i && !stall_i;
    assign base_idx  = lookup_pc_i[PC_LSB +: IDX_W];

`ifdef BRANCH_PHT_GSHARE_EN
    logic [IDX_W-1:0] ghr_q;
    logic [IDX_W-1:0] ghr_d;

    // Shift the resolved outcome into the history on each committed update.
    always_comb begin
        ghr_d = ghr_q;
        if (commit) ghr_d = IDX_W'({ghr_q, result_i});
    end

    // Global history register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ghr_q <= '0;
        else       ghr_q <= ghr_d;
    end

    assign look_idx = base_idx ^ ghr_q;
`else
    assign look_idx = base_idx;
`endif

    // Counter array; EX supplies the already-hashed index, so it is used as is.
    for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
        bp_sat_ctr #(
            .CTR_W    (CTR_W),
            .INIT_CTR (INIT_CTR)
        ) u_ctr (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .en_i    (commit && (update_idx_i == IDX_W'(i))),
            .taken_i (result_i),
            .ctr_o   (ctr_val[i])
        );
    end

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    assign predict_o    = ctr_val[look_idx][CTR_W-1];
    assign lookup_idx_o = look_idx;

    // Count committed mispredictions, holding at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (commit && (update_pred_i != result_i) && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    // Mispredict counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign mispredict_cnt_o = cnt_q;

endmodule

// File: tb/tb_branch_pht.sv
// Bench for branch_pht: directed scenarios plus randomized traffic compared
// against a behavioural table model. Honours BRANCH_PHT_GSHARE_EN.
module tb_branch_pht;

    localparam int ENTRIES = 64;
    localparam int CTR_W   = 2;
    localparam int INIT    = 2;
    localparam int PC_LSB  = 2;
    localparam int CNT_W   = 4;
    localparam int IDX_W   = 6;
    localparam int CTR_TOP = (1 << CTR_W) - 1;
    localparam int CNT_TOP = (1 << CNT_W) - 1;

    logic             clk_i = 0;
    logic             rst_i = 0;
    logic [31:0]      lookup_pc_i = 0;
    logic             predict_o;
    logic [IDX_W-1:0] lookup_idx_o;
    logic             update_i = 0;
    logic [IDX_W-1:0] update_idx_i = 0;
    logic             result_i = 0;
    logic             update_pred_i = 0;
    logic             stall_i = 0;
    logic [CNT_W-1:0] mispredict_cnt_o;

    branch_pht #(
        .ENTRIES (ENTRIES), .CTR_W (CTR_W), .INIT_CTR (INIT),
        .PC_LSB (PC_LSB), .CNT_W (CNT_W)
    ) dut (
        .clk_i (clk_i), .rst_i (rst_i), .lookup_pc_i (lookup_pc_i),
        .predict_o (predict_o), .lookup_idx_o (lookup_idx_o),
        .update_i (update_i), .update_idx_i (update_idx_i),
        .result_i (result_i), .update_pred_i (update_pred_i),
        .stall_i (stall_i), .mispredict_cnt_o (mispredict_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int passes = 0;

    // Reference model: plain integer table, history and miss count.
    int pht [ENTRIES];
    int ghr;
    int misses;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int model_idx(input logic [31:0] pc);
        int idx;
        idx = (pc >> PC_LSB) % ENTRIES;
`ifdef BRANCH_PHT_GSHARE_EN
        idx = idx ^ ghr;
`endif
        return idx;
    endfunction

    function automatic int model_pred(input logic [31:0] pc);
        return (pht[model_idx(pc)] >= (CTR_TOP + 1) / 2) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) pht[i] = INIT;
        ghr = 0;
        misses = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1;
        #1;
        model_reset();
        @(negedge clk_i);
        rst_i = 0;
    endtask

    // One cycle: drive at negedge, compare, then commit model at the posedge.
    task automatic cycle(input logic [31:0] pc, input logic upd, input int idx,
                         input logic res, input logic pred, input logic stl);
        @(negedge clk_i);
        lookup_pc_i   = pc;
        update_i      = upd;
        update_idx_i  = IDX_W'(idx);
        result_i      = res;
        update_pred_i = pred;
        stall_i       = stl;
        #1;
        check("predict", 32'(predict_o), 32'(model_pred(pc)));
        check("lookup_idx", 32'(lookup_idx_o), 32'(model_idx(pc)));
        check("mispredict_cnt", 32'(mispredict_cnt_o), 32'(misses));
        @(posedge clk_i);
        if (upd && !stl) begin
            if (res) pht[idx] = (pht[idx] < CTR_TOP) ? pht[idx] + 1 : CTR_TOP;
            else     pht[idx] = (pht[idx] > 0) ? pht[idx] - 1 : 0;
            if (res != pred && misses < CNT_TOP) misses++;
            ghr = ((ghr << 1) | int'(res)) % ENTRIES;
        end
    endtask

    // Lookup only, with an additional fixed expectation for predict_o.
    task automatic look(input string tag, input logic [31:0] pc, input logic exp);
        cycle(pc, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check(tag, 32'(predict_o), 32'(exp));
    endtask

    initial begin
        rst_i = 1;
        model_reset();
        #12;
        check("reset_cnt", 32'(mispredict_cnt_o), 32'd0);
        check("reset_pred", 32'(predict_o), 32'(INIT >> (CTR_W - 1)));
        rst_i = 0;

`ifndef BRANCH_PHT_GSHARE_EN
        // Collision: lookup 0x14 while idx 5 trains not-taken from 2.
        cycle(32'h14, 1'b1, 5, 1'b0, 1'b1, 1'b0);
        check("collision_same_cycle", 32'(predict_o), 32'd1);
        look("collision_next", 32'h14, 1'b0);
        cycle(32'h14, 1'b1, 5, 1'b0, 1'b0, 1'b0);
        look("sat_low", 32'h14, 1'b0);
        look("alias_0x114", 32'h114, 1'b0);
        look("alias_0x18", 32'h18, 1'b1);
        cycle(32'h0, 1'b1, 5, 1'b0, 1'b0, 1'b0);
        look("sat_low_hold", 32'h14, 1'b0);
        for (int k = 0; k < 4; k++) cycle(32'h0, 1'b1, 5, 1'b1, 1'b1, 1'b0);
        look("sat_high", 32'h14, 1'b1);
        cycle(32'h0, 1'b1, 5, 1'b0, 1'b1, 1'b1);
        look("stall_no_change", 32'h14, 1'b1);
        check("stall_cnt", 32'(mispredict_cnt_o), 32'd1);
`endif
        for (int k = 0; k < 17; k++) cycle(32'h0, 1'b1, 7, k[0], ~k[0], 1'b0);
        cycle(32'h0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("cnt_saturated", 32'(mispredict_cnt_o), 32'hF);

        // Asynchronous reset after training.
        do_reset();
        #1;
        check("reset_cnt_mid", 32'(mispredict_cnt_o), 32'd0);
        look("reset_pc_0x0", 32'h0, 1'b1);
        look("reset_pc_0x14", 32'h14, 1'b1);
        look("reset_pc_0xfc", 32'hFC, 1'b1);

        // History after outcomes T,N,T: gshare maps PC 0x14 to idx 0.
        cycle(32'h0, 1'b1, 9, 1'b1, 1'b1, 1'b0);
        cycle(32'h0, 1'b1, 9, 1'b0, 1'b1, 1'b0);
        cycle(32'h0, 1'b1, 9, 1'b1, 1'b1, 1'b0);
        cycle(32'h14, 1'b0, 0, 1'b0, 1'b0, 1'b0);
`ifdef BRANCH_PHT_GSHARE_EN
        check("ghr_idx", 32'(lookup_idx_o), 32'd0);
`else
        check("base_idx", 32'(lookup_idx_o), 32'd5);
`endif

        // Randomized traffic; small PC range to force aliasing and saturation.
        for (int k = 0; k < 600; k++) begin
            cycle({$urandom_range(0, 3), 2'b00, 6'($urandom), 2'($urandom)},
                  1'($urandom_range(0, 3) != 0), $urandom_range(0, 15),
                  1'($urandom), 1'($urandom), 1'($urandom_range(0, 4) == 0));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
